// File: rtl/sipo_window_ctrl_if.sv
// sipo_window_ctrl_if: groups the upstream sample handshake, the tap-register
// drive (data + shift enable) and the downstream window handshake.
// The master modport is the controller; the slave modport is the surrounding logic.
interface sipo_window_ctrl_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
);
   logic                         s_valid;
   logic [WIDTH-1:0]             s_data;
   logic                         s_ready;
   logic [WIDTH-1:0]             sipo_d;
   logic                         sipo_en;
   logic                         win_valid;
   logic                         win_ready;
   logic [7:0]                   win_count;
   // Observational count of valid samples held in the tap register.
   logic [$clog2(DEPTH+1)-1:0]   fill_cnt;

   modport master (
      input  s_valid, s_data, win_ready,
      output s_ready, sipo_d, sipo_en, win_valid, win_count, fill_cnt
   );

   modport slave (
      output s_valid, s_data, win_ready,
      input  s_ready, sipo_d, sipo_en, win_valid, win_count, fill_cnt
   );
endinterface

// File: rtl/sipo_window_ctrl.sv
// sipo_window_ctrl: sequencer for a DEPTH-stage, WIDTH-bit serial-in/parallel-out
// tap register. Accepts samples over valid/ready, drives the register's data and
// shift enable, and offers a "window valid" handshake to the parallel consumer.
// After the first full window, a new window is offered every STRIDE samples
// (STRIDE must lie in 1..DEPTH).
// Optional build macro: SIPO_WINDOW_CTRL_SKID_EN adds a one-sample skid buffer
// that lets the upstream hand over one sample while a window is pending.
module sipo_window_ctrl #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 8,
   parameter int STRIDE = 1
) (
   input  logic               clk,
   input  logic               rst,     // synchronous, active-low
   input  logic               flush,
   sipo_window_ctrl_if.master bus
);
   localparam int              CW          = $clog2(DEPTH + 1);
   localparam logic [0:0]      ST_FILL     = 1'b0;
   localparam logic [0:0]      ST_WAIT     = 1'b1;
   localparam logic [CW-1:0]   NEED_FULL   = CW'(DEPTH);
   localparam logic [CW-1:0]   NEED_STRIDE = CW'(STRIDE);

   logic [0:0]        state_q, state_d;
   logic [CW-1:0]     fill_cnt_q, fill_cnt_d;
   logic [CW-1:0]     need_cnt_q, need_cnt_d;
   logic              win_valid_q, win_valid_d;
   logic [7:0]        win_count_q, win_count_d;

   logic              s_ready;
   logic              shift_en;
   logic [WIDTH-1:0]  shift_d;
   logic              win_accept;

`ifdef SIPO_WINDOW_CTRL_SKID_EN
   logic [WIDTH-1:0]  skid_q, skid_d;
   logic              skid_full_q, skid_full_d;
`endif

   // Upstream ready and register drive; a pending skid sample always shifts first.
   always_comb begin
      s_ready  = 1'b0;
      shift_en = 1'b0;
      shift_d  = bus.s_data;
      if (rst && !flush) begin
         if (state_q == ST_FILL) begin
`ifdef SIPO_WINDOW_CTRL_SKID_EN
            if (skid_full_q) begin
               shift_en = 1'b1;
               shift_d  = skid_q;
            end else begin
               s_ready  = 1'b1;
               shift_en = bus.s_valid;
            end
`else
            s_ready  = 1'b1;
            shift_en = bus.s_valid;
`endif
         end
`ifdef SIPO_WINDOW_CTRL_SKID_EN
         else begin
            s_ready = ~skid_full_q;
         end
`endif
      end
   end

   assign win_accept = (state_q == ST_WAIT) && win_valid_q && bus.win_ready;

   // Window sequencing: count samples still needed, then hold the window until taken.
   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      need_cnt_d  = need_cnt_q;
      win_valid_d = win_valid_q;
      win_count_d = win_count_q;
      if (flush) begin
         state_d     = ST_FILL;
         fill_cnt_d  = '0;
         need_cnt_d  = NEED_FULL;
         win_valid_d = 1'b0;
      end else begin
         if (shift_en) begin
            if (fill_cnt_q != NEED_FULL) begin
               fill_cnt_d = fill_cnt_q + 1'b1;
            end
            need_cnt_d = need_cnt_q - 1'b1;
            if (need_cnt_q == CW'(1)) begin
               state_d     = ST_WAIT;
               win_valid_d = 1'b1;
            end
         end
         if (win_accept) begin
            win_count_d = win_count_q + 8'd1;
            need_cnt_d  = NEED_STRIDE;
            state_d     = ST_FILL;
            win_valid_d = 1'b0;
         end
      end
   end

`ifdef SIPO_WINDOW_CTRL_SKID_EN
   // Skid capture while a window is pending; drained on the first FILL cycle.
   always_comb begin
      skid_d      = skid_q;
      skid_full_d = skid_full_q;
      if (flush) begin
         skid_full_d = 1'b0;
      end else if (state_q == ST_WAIT) begin
         if (bus.s_valid && s_ready) begin
            skid_d      = bus.s_data;
            skid_full_d = 1'b1;
         end
      end else if (skid_full_q) begin
         skid_full_d = 1'b0;
      end
   end

   // Skid payload needs no reset; only the full flag is qualified by reset.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end
`endif

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_FILL;
         fill_cnt_q  <= '0;
         need_cnt_q  <= NEED_FULL;
         win_valid_q <= 1'b0;
         win_count_q <= 8'd0;
`ifdef SIPO_WINDOW_CTRL_SKID_EN
         skid_full_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         need_cnt_q  <= need_cnt_d;
         win_valid_q <= win_valid_d;
         win_count_q <= win_count_d;
`ifdef SIPO_WINDOW_CTRL_SKID_EN
         skid_full_q <= skid_full_d;
`endif
      end
   end

   assign bus.s_ready   = s_ready;
   assign bus.sipo_d    = shift_d;
   assign bus.sipo_en   = shift_en;
   assign bus.win_valid = win_valid_q;
   assign bus.win_count = win_count_q;
   assign bus.fill_cnt  = fill_cnt_q;
endmodule

// File: tb/tb_sipo_window_ctrl.sv
// tb_sipo_window_ctrl: two controllers (STRIDE=1 and STRIDE=4) share one stimulus
// stream. A behavioural window model per instance is checked every cycle, and
// a bench-side tap register built from each DUT's sipo_d/sipo_en is compared
// with the last DEPTH samples the model says were shifted.
`timescale 1ns/1ps
module tb_sipo_window_ctrl;
   localparam int W = 16;
   localparam int D = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          s_valid;
   logic [W-1:0]  s_data;
   logic          win_ready;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sipo_window_ctrl_if #(.WIDTH(W), .DEPTH(D)) b1 ();
   sipo_window_ctrl_if #(.WIDTH(W), .DEPTH(D)) b4 ();

   assign b1.s_valid   = s_valid;
   assign b1.s_data    = s_data;
   assign b1.win_ready = win_ready;
   assign b4.s_valid   = s_valid;
   assign b4.s_data    = s_data;
   assign b4.win_ready = win_ready;

   sipo_window_ctrl #(.WIDTH(W), .DEPTH(D), .STRIDE(1)) u1 (
      .clk(clk), .rst(rst), .flush(flush), .bus(b1));
   sipo_window_ctrl #(.WIDTH(W), .DEPTH(D), .STRIDE(4)) u4 (
      .clk(clk), .rst(rst), .flush(flush), .bus(b4));

   // Bench-side tap registers: index D-1 is a7 (newest), index 0 is a0 (oldest).
   logic [W-1:0] taps [2][D];
   int           en_cnt [2] = '{0, 0};

   always @(posedge clk) begin
      if (b1.sipo_en) begin
         for (int k = 0; k < D-1; k++) taps[0][k] <= taps[0][k+1];
         taps[0][D-1] <= b1.sipo_d;
         en_cnt[0]    <= en_cnt[0] + 1;
      end
      if (b4.sipo_en) begin
         for (int k = 0; k < D-1; k++) taps[1][k] <= taps[1][k+1];
         taps[1][D-1] <= b4.sipo_d;
         en_cnt[1]    <= en_cnt[1] + 1;
      end
   end

   // Behavioural model state per instance (starts in the post-reset condition).
   int           m_stride [2] = '{1, 4};
   int           m_need   [2] = '{D, D};
   int           m_fill   [2] = '{0, 0};
   int           m_cnt    [2] = '{0, 0};
   bit           m_win    [2] = '{1'b0, 1'b0};
   bit           m_skid   [2] = '{1'b0, 1'b0};
   logic [W-1:0] m_skid_d [2];
   logic [W-1:0] m_hist   [2][D];

   task automatic cmp(input string nm, input int i, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s [u%0d] t=%0t got %0h expected %0h", nm, (i == 0) ? 1 : 4,
                  $time, act, exp);
      end
   endtask

   task automatic check_inst(input int i, input logic sr, input logic en,
                             input logic [W-1:0] d, input logic wv,
                             input logic [7:0] wc, input logic [3:0] fc);
      logic         e_sr, e_en;
      logic [W-1:0] e_d;
      bit           was_win;
      e_sr = 1'b0;
      e_en = 1'b0;
      e_d  = s_data;
      if (rst && !flush) begin
         if (!m_win[i]) begin
            if (m_skid[i]) begin
               e_en = 1'b1;
               e_d  = m_skid_d[i];
            end else begin
               e_sr = 1'b1;
               e_en = s_valid;
            end
         end else begin
`ifdef SIPO_WINDOW_CTRL_SKID_EN
            e_sr = !m_skid[i];
`endif
         end
      end
      cmp("s_ready",   i, 32'(sr), 32'(e_sr));
      cmp("sipo_en",   i, 32'(en), 32'(e_en));
      if (e_en) cmp("sipo_d", i, 32'(d), 32'(e_d));
      cmp("win_valid", i, 32'(wv), 32'(m_win[i]));
      cmp("win_count", i, 32'(wc), 32'(m_cnt[i] % 256));
      cmp("fill_cnt",  i, 32'(fc), 32'(m_fill[i]));
      if (m_win[i]) begin
         for (int k = 0; k < D; k++) cmp("tap", i, 32'(taps[i][k]), 32'(m_hist[i][k]));
      end
      // Advance the model to the state after the coming clock edge.
      was_win = m_win[i];
      if (!rst) begin
         m_need[i] = D; m_fill[i] = 0; m_cnt[i] = 0; m_win[i] = 1'b0; m_skid[i] = 1'b0;
      end else if (flush) begin
         m_need[i] = D; m_fill[i] = 0; m_win[i] = 1'b0; m_skid[i] = 1'b0;
      end else if (was_win) begin
         if (e_sr && s_valid) begin
            m_skid[i]   = 1'b1;
            m_skid_d[i] = s_data;
         end
         if (win_ready) begin
            m_cnt[i]  = m_cnt[i] + 1;
            m_win[i]  = 1'b0;
            m_need[i] = m_stride[i];
         end
      end else if (e_en) begin
         for (int k = 0; k < D-1; k++) m_hist[i][k] = m_hist[i][k+1];
         m_hist[i][D-1] = e_d;
         m_skid[i] = 1'b0;
         if (m_fill[i] < D) m_fill[i] = m_fill[i] + 1;
         m_need[i] = m_need[i] - 1;
         if (m_need[i] == 0) m_win[i] = 1'b1;
      end
   endtask

   // One clock cycle: model check at the falling edge, then settle just past the rising edge.
   task automatic step();
      @(negedge clk);
      check_inst(0, b1.s_ready, b1.sipo_en, b1.sipo_d, b1.win_valid, b1.win_count, b1.fill_cnt);
      check_inst(1, b4.s_ready, b4.sipo_en, b4.sipo_d, b4.win_valid, b4.win_count, b4.fill_cnt);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] v);
      s_valid = 1'b1;
      s_data  = v;
      step();
      s_valid = 1'b0;
   endtask

   int en_snap;

   initial begin
      rst = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; win_ready = 1'b0;
      repeat (2) step();
      rst = 1'b1;

      // Prime: eight contiguous samples fill the register.
      for (int k = 1; k <= D; k++) begin
         s_valid = 1'b1;
         s_data  = W'(k);
         step();
         if (k == D-1) cmp("prime win_valid early", 0, 32'(b1.win_valid), 0);
      end
      s_valid = 1'b0;
      cmp("prime win_valid", 0, 32'(b1.win_valid), 1);
      cmp("prime win_valid", 1, 32'(b4.win_valid), 1);
      cmp("prime a7", 0, 32'(taps[0][D-1]), 32'h8);
      cmp("prime a0", 0, 32'(taps[0][0]), 32'h1);
      cmp("prime en pulses", 0, 32'(en_cnt[0]), 8);
      cmp("prime fill_cnt", 0, 32'(b1.fill_cnt), 8);

      // Backpressure: window held, taps frozen.
`ifdef SIPO_WINDOW_CTRL_SKID_EN
      s_valid = 1'b0;
`else
      s_valid = 1'b1;
`endif
      s_data = 16'h0055;
      repeat (10) step();
`ifndef SIPO_WINDOW_CTRL_SKID_EN
      cmp("bp s_ready", 0, 32'(b1.s_ready), 0);
`endif
      cmp("bp sipo_en", 0, 32'(b1.sipo_en), 0);
      cmp("bp win_valid", 0, 32'(b1.win_valid), 1);
      cmp("bp a7", 0, 32'(taps[0][D-1]), 32'h8);
      cmp("bp en pulses", 0, 32'(en_cnt[0]), 8);
      s_valid = 1'b0;
      win_ready = 1'b1;
      step();
      cmp("release count", 0, 32'(b1.win_count), 1);
      cmp("release count", 1, 32'(b4.win_count), 1);
      cmp("release win_valid", 0, 32'(b1.win_valid), 0);

      // Sliding window (u1) and stride accumulation (u4).
      send(16'h0009);
      cmp("slide win_valid", 0, 32'(b1.win_valid), 1);
      cmp("slide a7", 0, 32'(taps[0][D-1]), 32'h9);
      cmp("slide a0", 0, 32'(taps[0][0]), 32'h2);
      step();
      cmp("slide count", 0, 32'(b1.win_count), 2);
      send(16'h000A);
      cmp("slide a7", 0, 32'(taps[0][D-1]), 32'hA);
      cmp("slide a0", 0, 32'(taps[0][0]), 32'h3);
      step();
      cmp("slide count", 0, 32'(b1.win_count), 3);
      send(16'h000B);
      cmp("stride 3 samples win_valid", 1, 32'(b4.win_valid), 0);
      step();
      send(16'h000C);
      cmp("stride 4th sample win_valid", 1, 32'(b4.win_valid), 1);
      cmp("stride a7", 1, 32'(taps[1][D-1]), 32'hC);
      step();
      cmp("stride count", 0, 32'(b1.win_count), 5);
      cmp("stride count", 1, 32'(b4.win_count), 2);

      // Flush mid-fill: the concurrent sample is dropped, full refill required.
      win_ready = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int k = 0; k < 5; k++) begin
         s_valid = 1'b1;
         s_data  = W'(16'h21 + k);
         step();
      end
      en_snap = en_cnt[0];
      flush = 1'b1; s_valid = 1'b1; s_data = 16'h0099;
      step();
      flush = 1'b0;
      cmp("flush drop a7", 0, 32'(taps[0][D-1]), 32'h25);
      cmp("flush drop en", 0, 32'(en_cnt[0]), 32'(en_snap));
      cmp("flush fill_cnt", 0, 32'(b1.fill_cnt), 0);
      for (int k = 0; k < D; k++) begin
         s_valid = 1'b1;
         s_data  = W'(16'h31 + k);
         step();
         if (k == D-2) cmp("refill early win_valid", 0, 32'(b1.win_valid), 0);
      end
      s_valid = 1'b0;
      cmp("refill win_valid", 0, 32'(b1.win_valid), 1);
      cmp("refill a7", 0, 32'(taps[0][D-1]), 32'h38);
      cmp("refill a0", 0, 32'(taps[0][0]), 32'h31);
      cmp("refill count", 0, 32'(b1.win_count), 5);
      cmp("refill count", 1, 32'(b4.win_count), 2);
      win_ready = 1'b1;
      step();
      win_ready = 1'b0;
      cmp("post-flush count", 0, 32'(b1.win_count), 6);

`ifdef SIPO_WINDOW_CTRL_SKID_EN
      // Skid: one sample parked during WAIT, replayed first after acceptance.
      send(16'h0040);
      s_valid = 1'b1; s_data = 16'h00AA;
      step();
      cmp("skid taps held", 0, 32'(taps[0][D-1]), 32'h40);
      s_data = 16'h00BB;
      cmp("skid second s_ready", 0, 32'(b1.s_ready), 0);
      step();
      s_valid = 1'b0; win_ready = 1'b1;
      step();
      cmp("skid drain en", 0, 32'(b1.sipo_en), 1);
      cmp("skid drain d", 0, 32'(b1.sipo_d), 32'h00AA);
      win_ready = 1'b0;
`endif

      // Randomized traffic with occasional flush and reset.
      for (int n = 0; n < 3000; n++) begin
         s_valid   = ($urandom_range(0, 3) != 0);
         s_data    = W'($urandom);
         win_ready = ($urandom_range(0, 1) != 0);
         flush     = ($urandom_range(0, 63) == 0);
         rst       = ($urandom_range(0, 255) != 0);
         step();
      end
      rst = 1'b1; flush = 1'b0; s_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
